// File: rtl/feeder_pkg.sv
// feeder_pkg: shared state encoding and default geometry for the skewed data feeder
package feeder_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 7;
  localparam int DEF_LANES  = 4;
endpackage

// File: rtl/lane_shift_reg.sv
// lane_shift_reg: one lane's burst store; ports clk, reset, load/load_data (parallel load), shift (drop head, pull next), head (current element)
module lane_shift_reg import feeder_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    shift,
  input  logic [DEPTH*DATA_W-1:0] load_data,
  output logic [DATA_W-1:0]       head
);
  logic [DEPTH*DATA_W-1:0] store_q;
  always_ff @(posedge clk)
    if (reset) store_q <= '0;
    else if (load) store_q <= load_data;
    else if (shift) store_q <= store_q << DATA_W;
  assign head = store_q[DEPTH*DATA_W-1 -: DATA_W];
endmodule

// File: rtl/skewed_data_feeder.sv
// skewed_data_feeder: streams a burst into LANES lanes, lane i delayed by i steps (systolic skew).
// Ports: clk, reset, load_valid/load_ready/load_data (burst in), enable (step), data_out/out_valid (per lane),
// busy, done. Define FEEDER_AUTO_RUN_EN to ignore enable and step every cycle while streaming.
module skewed_data_feeder import feeder_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int LANES  = DEF_LANES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [LANES*DEPTH*DATA_W-1:0] load_data,
  input  logic                          enable,
  output logic [LANES*DATA_W-1:0]       data_out,
  output logic [LANES-1:0]              out_valid,
  output logic                          busy,
  output logic                          done
);
  localparam int TW = $clog2(DEPTH + LANES);
  localparam int LAST = DEPTH + LANES - 2;
  state_e state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [LANES*DATA_W-1:0] dout_q, dout_d;
  logic [LANES-1:0] vld_q, vld_d, shift;
  logic done_q, done_d, load, step;
  logic [DATA_W-1:0] head [LANES];
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_shift_reg #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .shift    (shift[g]),
      .load_data(load_data[g*DEPTH*DATA_W +: DEPTH*DATA_W]),
      .head     (head[g])
    );
  end
`ifdef FEEDER_AUTO_RUN_EN
  logic unused_enable;
  assign unused_enable = enable;
  assign step = state_q == STREAM;
`else
  assign step = state_q == STREAM && enable;
`endif
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    dout_d = dout_q;
    vld_d = vld_q;
    done_d = 1'b0;
    load = 1'b0;
    shift = '0;
    if (state_q == IDLE && load_valid) begin
      load = 1'b1;
      t_d = '0;
      dout_d = '0;
      vld_d = '0;
      state_d = STREAM;
    end else if (step) begin
      // lane i is live while 0 <= t-i < DEPTH; each live step consumes its head
      for (int i = 0; i < LANES; i++) begin
        vld_d[i] = int'(t_q) >= i && int'(t_q) - i < DEPTH;
        dout_d[i*DATA_W +: DATA_W] = vld_d[i] ? head[i] : '0;
        shift[i] = vld_d[i];
      end
      t_d = t_q + 1'b1;
      state_d = t_q == TW'(LAST) ? FLUSH : STREAM;
    end else if (state_q == FLUSH) begin
      dout_d = '0;
      vld_d = '0;
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      t_q <= '0;
      dout_q <= '0;
      vld_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      dout_q <= dout_d;
      vld_q <= vld_d;
      done_q <= done_d;
    end
  assign load_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign data_out = dout_q;
  assign out_valid = vld_q;
  assign done = done_q;
endmodule

// File: doc/skewed_data_feeder.md
SKEWED_DATA_FEEDER -- requirements
Module: skewed_data_feeder

Interface
REQ-001 SHALL have parameter DATA_W, default 8: element width in bits.
REQ-002 SHALL have parameter DEPTH, default 7: elements per lane per burst.
REQ-003 SHALL have parameter LANES, default 4: number of output lanes (systolic rows).
REQ-004 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port load_valid  input  1: burst offered on load_data.
REQ-007 SHALL have port load_ready  output  1: block accepts a burst this cycle.
REQ-008 SHALL have port load_data  input  LANES*DEPTH*DATA_W: lane i in slice [(i+1)*DEPTH*DATA_W-1 : i*DEPTH*DATA_W]; element 0 is the most-significant DATA_W bits of the slice.
REQ-009 SHALL have port enable  input  1: advance stream one step.
REQ-010 SHALL have port data_out  output  LANES*DATA_W: lane i in bits [(i+1)*DATA_W-1 : i*DATA_W].
REQ-011 SHALL have port out_valid  output  LANES: per-lane element-valid flag.
REQ-012 SHALL have port busy  output  1: high in STREAM or FLUSH.
REQ-013 SHALL have port done  output  1: one-cycle pulse at burst end.

Function
REQ-014 SHALL implement states IDLE, STREAM, FLUSH.
REQ-015 load_ready SHALL be combinationally high only in IDLE.
REQ-016 In IDLE, load_valid && load_ready SHALL capture load_data into all lanes, clear step counter t to 0, clear data_out/out_valid, and enter STREAM; a simultaneous enable SHALL be ignored.
REQ-017 In STREAM, each clock edge with enable high SHALL register, for every lane i, data_out lane i = element (t-i) with out_valid[i]=1 when 0 <= t-i < DEPTH, else data_out lane i = 0 and out_valid[i]=0; then t increments.
REQ-018 With enable low in STREAM, data_out, out_valid and t SHALL hold (stall).
REQ-019 The step with t = DEPTH+LANES-2 SHALL be the last; on that edge the state SHALL move to FLUSH.
REQ-020 In FLUSH, the next clock edge (enable ignored) SHALL clear data_out and out_valid, assert done for exactly that one cycle, and return to IDLE.
REQ-021 load_valid outside IDLE SHALL be ignored with no effect on state or data.
REQ-022 Latency: first valid lane-0 element appears on the first enable edge after load acceptance; a burst occupies exactly DEPTH+LANES-1 enabled steps plus one FLUSH cycle.
REQ-023 t SHALL be sized $clog2(DEPTH+LANES) bits and never wrap within a burst.

Reset
REQ-024 Reset SHALL take priority over all inputs, including mid-burst.
REQ-025 On reset: state IDLE, t=0, lane storage 0, data_out=0, out_valid=0, busy=0, done=0, load_ready=1 the following cycle.

Configuration
REQ-026 With macro FEEDER_AUTO_RUN_EN defined, enable SHALL be ignored and STREAM SHALL advance on every clock edge.
REQ-027 Without FEEDER_AUTO_RUN_EN, stepping SHALL follow enable per REQ-017/018; port list SHALL be identical in both builds.

Structure
REQ-028 Package feeder_pkg SHALL hold the state enum typedef and default DATA_W/DEPTH/LANES constants.
REQ-029 Sub-module lane_shift_reg (parallel load, shift-by-one on shift enable, DATA_W output) SHALL be instantiated LANES times; skew gating and counter live in the top.

Verification (DATA_W=8, DEPTH=7, LANES=4)
REQ-030 Load lane0=56'h11223344556677, lanes1-3=56'hA1B2C3D4E5F607, enable held high -> lane0 emits 11,22,...,77 on steps 0-6; lane1 emits A1..07 on steps 1-7; lane3 starts on step 3 and ends on step 9; done pulses one cycle after step 9.
REQ-031 Same load, enable toggling 1/0 -> identical sequence, outputs held during every low cycle, 10 enabled steps total.
REQ-032 Assert reset at step 4 -> next edge all outputs 0, load_ready=1; a fresh load then restarts at step 0 cleanly.
REQ-033 load_valid with new data during STREAM -> ignored; streamed values remain from the original burst.
REQ-034 load_valid and enable both high in IDLE -> burst captured, out_valid stays 0, t remains 0.
REQ-035 Build with FEEDER_AUTO_RUN_EN, enable tied 0 -> full burst streams on consecutive cycles, done 10 cycles after the cycle following acceptance.
